// File: rtl/mac_acc_ctrl_pkg.sv
// Shared definitions for the MAC accumulator slice: state encodings,
// default sizing and a constant-capable clog2.
package mac_defs;

    localparam int unsigned DEF_PROD_WIDTH = 16;
    localparam int unsigned DEF_ACC_WIDTH  = 19;
    localparam int unsigned DEF_N_TAPS     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/mac_tap_counter.sv
// Tap counter for one accumulation: clears on start, advances per accepted
// product and flags the accept that completes the last tap.
module mac_tap_counter
    import mac_defs::*;
#(
    parameter int unsigned N_TAPS = DEF_N_TAPS,
    parameter int unsigned CNT_W  = clog2(N_TAPS)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    assign last = inc && (cnt == CNT_W'(N_TAPS - 1));

    // Wraps to zero on the terminal accept so cnt never exceeds N_TAPS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mac_acc_ctrl.sv
// Accumulator register and sequencing FSM for the MAC datapath.
// Define MAC_SAT_EN to saturate the accumulation instead of wrapping.
module mac_acc_ctrl
    import mac_defs::*;
#(
    parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned N_TAPS     = DEF_N_TAPS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         prod_valid,
    input  logic signed [PROD_WIDTH-1:0] prod_in,
    output logic                         prod_ready,
    output logic signed [ACC_WIDTH-1:0]  acc_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    state_t                       state;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  sum_wrap;
    logic signed [ACC_WIDTH-1:0]  sum_next;
    logic                         accept;
    logic                         handshake;
    logic                         clear;
    logic                         last;

    assign accept    = prod_valid && prod_ready;
    assign handshake = out_valid && out_ready;
    assign clear     = start && ((state == IDLE) || ((state == DONE) && out_ready));
    assign acc_out   = acc;

    always_comb begin
        prod_ext = ACC_WIDTH'(prod_in);
        sum_wrap = acc + prod_ext;
`ifdef MAC_SAT_EN
        // Overflow only when both operands share a sign the result lacks.
        if ((acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
            (sum_wrap[ACC_WIDTH-1] != acc[ACC_WIDTH-1])) begin
            sum_next = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            sum_next = sum_wrap;
        end
`else
        sum_next = sum_wrap;
`endif
    end

    mac_tap_counter #(
        .N_TAPS (N_TAPS)
    ) u_tap_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (accept),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            prod_ready <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        acc        <= '0;
                        prod_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= sum_next;
                        if (last) begin
                            state      <= DONE;
                            prod_ready <= 1'b0;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        // Back-to-back restart skips IDLE entirely.
                        if (start) begin
                            state      <= ACCUM;
                            acc        <= '0;
                            prod_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    prod_ready <= 1'b0;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_acc_ctrl.md
Name: mac_acc_ctrl

Overview:
- Sequencing and accumulator-register stage of the MAC datapath.
- Accepts a stream of signed products and holds the accumulator register.
- Drives the clear/accumulate select internally: clear on start, accumulate per accepted product.
- After N_TAPS products, presents the final sum to the downstream consumer through a valid/ready handshake.

Parameters:
PROD_WIDTH, 16, width of signed product input
ACC_WIDTH, 19, accumulator width; must be at least PROD_WIDTH + clog2(N_TAPS) to avoid wrap
N_TAPS, 8, products accumulated per result (at least 2)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: begin a new accumulation
prod_valid  in  1  prod_in is valid this cycle
prod_in  in  PROD_WIDTH  signed product
prod_ready  out  1  block accepts a product this cycle
acc_out  out  ACC_WIDTH  signed accumulated result
out_valid  out  1  acc_out is final
out_ready  in  1  consumer accepts acc_out
busy  out  1  high in ACCUM or DONE

Behaviour:
- Reset (async, active-high): state=IDLE, acc=0, cnt=0; prod_ready=0, out_valid=0, busy=0, acc_out=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - prod_ready=0.
  - start=1 -> acc<=0, cnt<=0, next=ACCUM (this is the clear path, select=0).
- ACCUM:
  - prod_ready=1.
  - Accept = prod_valid & prod_ready.
  - On accept: acc <= acc + sign_extend(prod_in) to ACC_WIDTH; cnt++.
  - Accept with cnt==N_TAPS-1 -> next=DONE.
  - No accept -> acc and cnt hold.
  - start is ignored in ACCUM.
- DONE:
  - out_valid=1; acc_out=acc, held stable until the handshake.
  - prod_ready=0; prod_in is ignored.
  - out_valid & out_ready -> IDLE.
  - Same cycle also has start=1 -> acc<=0, cnt<=0, next=ACCUM directly, no bubble.
- acc_out is registered (equals acc) in all states; 0 after reset.
- Latency: out_valid rises the cycle after the Nth accept. Minimum start-to-out_valid is N_TAPS+1 cycles.
- Arithmetic: two's complement; the sum wraps modulo 2^ACC_WIDTH unless MAC_SAT_EN is defined.
- cnt width is clog2(N_TAPS); cnt never exceeds N_TAPS-1.
- Reset asserted mid-accumulation aborts immediately and discards the partial sum. There is no resume.
- start and prod_valid in the same IDLE cycle: start wins; the product is not accepted (prod_ready=0).

Optional Feature:
- Macro MAC_SAT_EN.
- Defined: the addition saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Overflow is detected from operand and result signs.
  - Once saturated, later accepts still add, and saturate again if they overflow.
- Undefined: plain wrapping addition; no extra logic.

Decomposition:
- Shared header/package mac_defs:
  - state encodings IDLE=2'd0, ACCUM=2'd1, DONE=2'd2
  - default PROD_WIDTH/ACC_WIDTH/N_TAPS
  - clog2 function
- Sub-module mac_tap_counter: clear, increment-on-accept, terminal-count flag (cnt==N_TAPS-1 & inc).
- Adder and saturation stay inline.

Test Plan:
- Reset mid-ACCUM after 3 products -> every output is 0 asynchronously; state IDLE; the next start gives a clean sum.
- start, then 8 products of +100 back-to-back with out_ready=1 -> out_valid one cycle after the 8th accept, acc_out=800, then IDLE.
- Products 32767,-32768 alternating x8 -> acc_out=-4. Products -32768 x8 -> acc_out=-262144 (exact min, no wrap).
- prod_valid toggled every other cycle, out_ready held 0 for 5 cycles -> acc_out=sum, stable and held with out_valid=1 until out_ready; products offered in DONE are not accepted.
- out_ready and start in the same DONE cycle, then 8 products of +1 -> second result=8; first result unaffected; no idle cycle.
- N_TAPS=16, products 32767 x16:
  - without MAC_SAT_EN -> acc_out=-16
  - with MAC_SAT_EN -> acc_out=262143
